// File: rtl/link_pkg.sv
// Shared types for the inter-core link transmitter: link packet layout and TX FSM states.
package link_pkg;

   localparam int LINK_W    = 34;
   localparam int PAYLOAD_W = 32;
   localparam int CORE_ID_W = 2;

   typedef struct packed {
      logic [CORE_ID_W-1:0] dest;
      logic [PAYLOAD_W-1:0] payload;
   } link_pkt_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } tx_state_t;

endpackage

// File: rtl/link_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count; head word read combinationally.
module link_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 34
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [WIDTH-1:0]       i_wdata,
   output logic [WIDTH-1:0]       o_rdata,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   // Full blocks a push even when a pop happens in the same cycle (no bypass).
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/link_tx.sv
// Link transmitter: buffers local packets and drives them to the neighbour router with a
// level req held until ack. Handshake: a packet moves when send_req && recieve_ack at a clk edge.
module link_tx
   import link_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [CORE_ID_W-1:0]   in_dest,
   input  logic [PAYLOAD_W-1:0]   in_payload,
   output logic                   in_ready,
   output logic                   send_req,
   output logic [LINK_W-1:0]      send_packet,
   input  logic                   recieve_ack,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [CNT_W-1:0]       sent_count,
   output logic                   timeout_err,
   output tx_state_t              dbg_state
);

   localparam int              TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT);

   tx_state_t        r_state;
   tx_state_t        w_state_nxt;
   link_pkt_t        r_pkt;
   link_pkt_t        w_in_pkt;
   link_pkt_t        w_head;
   logic [TW-1:0]    r_wait;
   logic [TW-1:0]    w_wait_inc;
   logic [CNT_W-1:0] r_sent;
   logic             r_err;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_load;
   logic             w_ack;

   assign in_ready    = !w_full && !rst;
   assign w_in_pkt    = '{dest: in_dest, payload: in_payload};
   assign send_req    = (r_state == WAIT);
   assign send_packet = r_pkt;
   assign sent_count  = r_sent;
   assign timeout_err = r_err;
   assign dbg_state   = r_state;
   assign w_wait_inc  = (r_wait == TMAX) ? r_wait : r_wait + 1'b1;

   link_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (LINK_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (in_valid && in_ready),
      .i_pop   (w_pop),
      .i_wdata (w_in_pkt),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_load      = 1'b0;
      w_ack       = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_load      = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (recieve_ack) begin
               w_ack = 1'b1;
               // Back-to-back: reload in the ack cycle so req never drops.
               if (!w_empty) begin
                  w_pop  = 1'b1;
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_pkt   <= '0;
         r_wait  <= '0;
         r_sent  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) r_pkt <= w_head;
         if (w_ack) begin
            r_sent <= r_sent + 1'b1;
            r_wait <= '0;
         end else if (r_state == WAIT) begin
            r_wait <= w_wait_inc;
            if (TIMEOUT != 0 && w_wait_inc == TMAX) r_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_link_tx.sv
// Self-checking bench for link_tx: occupancy/handshake reference model plus packet-order scoreboard.
module tb_link_tx;
  import link_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic [1:0]             in_dest = '0;
  logic [31:0]            in_payload = '0;
  logic                   in_ready;
  logic                   send_req;
  logic [LINK_W-1:0]      send_packet;
  logic                   recieve_ack = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0]       sent_count;
  logic                   timeout_err;
  tx_state_t              dbg_state;

  link_tx #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_dest     (in_dest),
    .in_payload  (in_payload),
    .in_ready    (in_ready),
    .send_req    (send_req),
    .send_packet (send_packet),
    .recieve_ack (recieve_ack),
    .fifo_count  (fifo_count),
    .sent_count  (sent_count),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_hs     = 0;

  logic [LINK_W-1:0] exp_q[$];

  // reference model state: FIFO occupancy, link busy, counters
  int               m_fill;
  logic             m_busy;
  logic [CNT_W-1:0] m_sent;
  int               m_wait;
  logic             m_err;
  logic             m_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: packets leave in acceptance order; one moves onto the link whenever
  // the link is free, or is freed by an ack, and the buffer holds something
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fill = 0;
      m_busy = 1'b0;
      m_sent = '0;
      m_wait = 0;
      m_err  = 1'b0;
      exp_q.delete();
    end else begin
      m_acc = in_valid && (m_fill < DEPTH);
      if (m_acc) exp_q.push_back({in_dest, in_payload});
      if (!m_busy) begin
        if (m_fill > 0) begin
          m_busy = 1'b1;
          m_fill = m_fill - 1;
          m_wait = 0;
        end
      end else if (recieve_ack) begin
        m_sent = m_sent + 1'b1;
        m_wait = 0;
        if (m_fill > 0) m_fill = m_fill - 1;
        else m_busy = 1'b0;
      end else begin
        m_wait = m_wait + 1;
        if (m_wait >= TIMEOUT) m_err = 1'b1;
      end
      if (m_acc) m_fill = m_fill + 1;
    end
  end

  // monitor: compare visible state every cycle; pop the scoreboard on each handshake
  logic [LINK_W-1:0] exp_pkt;
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 64'(in_ready), 64'(m_fill < DEPTH));
      chk("send_req", 64'(send_req), 64'(m_busy));
      chk("fifo_count", 64'(fifo_count), 64'(m_fill));
      chk("sent_count", 64'(sent_count), 64'(m_sent));
      chk("timeout_err", 64'(timeout_err), 64'(m_err));
      chk("dbg_state", 64'(dbg_state), 64'(m_busy ? WAIT : IDLE));
      if (send_req && recieve_ack) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_empty send_packet=%0h expected no packet at %0t", send_packet, $time);
        end else begin
          exp_pkt = exp_q.pop_front();
          chk("send_packet", 64'(send_packet), 64'(exp_pkt));
        end
      end
    end
  end

  // driver: apply inputs just after an edge, then advance one cycle
  task automatic drive(input logic v, input logic [1:0] d, input logic [31:0] p, input logic a);
    in_valid    = v;
    in_dest     = d;
    in_payload  = p;
    recieve_ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  int hs0;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_send_req", 64'(send_req), 64'd0);
    chk("rst_send_packet", 64'(send_packet), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_sent_count", 64'(sent_count), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // single packet: req after the following edge, ack two cycles after the push
    drive(1'b1, 2'b10, 32'hDEADBEEF, 1'b0);
    chk("single_req_early", 64'(send_req), 64'd0);
    drive(1'b0, 2'b00, 32'h0, 1'b0);
    chk("single_req", 64'(send_req), 64'd1);
    chk("single_pkt", 64'(send_packet), 64'h2DEADBEEF);
    drive(1'b0, 2'b00, 32'h0, 1'b1);
    chk("single_req_drop", 64'(send_req), 64'd0);
    chk("single_sent", 64'(sent_count), 64'd1);

    // back-to-back with ack held high
    for (int i = 1; i <= 4; i++) drive(1'b1, 2'b01, 32'(i), 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 2'b00, 32'h0, 1'b1);
    chk("b2b_fifo_count", 64'(fifo_count), 64'd0);
    chk("b2b_sent", 64'(sent_count), 64'd5);

    // spurious ack while idle
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 32'h0, 1'b1);
    chk("spur_sent", 64'(sent_count), 64'd5);
    chk("spur_req", 64'(send_req), 64'd0);

    // timeout: error after the 8th no-ack WAIT cycle, transfer still completes
    drive(1'b1, 2'b11, 32'h12345678, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, 2'b00, 32'h0, 1'b0);
    chk("tmo_early", 64'(timeout_err), 64'd0);
    drive(1'b0, 2'b00, 32'h0, 1'b0);
    chk("tmo_set", 64'(timeout_err), 64'd1);
    chk("tmo_req_held", 64'(send_req), 64'd1);
    drive(1'b0, 2'b00, 32'h0, 1'b1);
    chk("tmo_sticky", 64'(timeout_err), 64'd1);
    chk("tmo_sent", 64'(sent_count), 64'd6);

    // reset while in WAIT with 3 queued
    for (int i = 0; i < 4; i++) drive(1'b1, 2'b00, 32'hA0 + 32'(i), 1'b0);
    chk("mid_fifo_count", 64'(fifo_count), 64'd3);
    chk("mid_req", 64'(send_req), 64'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 64'(send_req), 64'd0);
    chk("mid_rst_fifo", 64'(fifo_count), 64'd0);
    chk("mid_rst_sent", 64'(sent_count), 64'd0);
    chk("mid_rst_err", 64'(timeout_err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, 32'h0, 1'b1);
    chk("no_stale_req", 64'(send_req), 64'd0);
    chk("no_stale_fifo", 64'(fifo_count), 64'd0);

    // full / backpressure: 6 offers, 5 accepted
    hs0 = n_hs;
    for (int i = 0; i < 6; i++) drive(1'b1, 2'(i), 32'h100 + 32'(i), 1'b0);
    chk("full_fifo_count", 64'(fifo_count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) drive(1'b0, 2'b00, 32'h0, 1'b1);
    drive(1'b0, 2'b00, 32'h0, 1'b1);
    chk("full_seen", 64'(n_hs - hs0), 64'd5);

    // randomized traffic (sent_count wraps at 16)
    for (int i = 0; i < 500; i++)
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            ($urandom_range(0, 99) < 60));

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) drive(1'b0, 2'b00, 32'h0, 1'b1);
    drive(1'b0, 2'b00, 32'h0, 1'b0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain outstanding=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
